// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and defaults, common to ctr, the instruction memory and decode.
package fetch_unit_pkg;

  localparam int DEFAULT_ADDR_W   = 10;
  localparam int DEFAULT_WORD_W   = 16;
  localparam int DEFAULT_LONG_BIT = 15;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef enum logic {
    F1 = 1'b0,
    F2 = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_out_reg.sv
// Output register toward decode: flush beats load, load beats consume, otherwise hold.
// Loaded contents appear one clock after load; contents are held while decode is not ready.
module fetch_out_reg
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int WORD_W = DEFAULT_WORD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  flush,
  input  logic                  consume,
  input  logic [2*WORD_W-1:0]   load_instr,
  input  logic [ADDR_W-1:0]     load_pc,
  input  logic                  load_long,
  output logic                  instr_valid,
  output logic [2*WORD_W-1:0]   instr,
  output logic [ADDR_W-1:0]     instr_pc,
  output logic                  instr_long
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_long  <= 1'b0;
    end else if (flush) begin
      instr_valid <= 1'b0;
    end else if (load) begin
      instr_valid <= 1'b1;
      instr       <= load_instr;
      instr_pc    <= load_pc;
      instr_long  <= load_long;
    end else if (consume) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: assembles one/two-word instructions from imem at the PC and steers the counter.
// One-word instr valid one clock after its PC; held (pc_en=0) while decode stalls; redirect wins over everything.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int WORD_W   = DEFAULT_WORD_W,
  parameter int LONG_BIT = DEFAULT_LONG_BIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     pc_val,
  output logic                  pc_en,
  output logic                  pc_dir,
  output logic                  pc_jmp,
  output logic [ADDR_W-1:0]     pc_jmp_loc,
  output logic [ADDR_W-1:0]     imem_addr,
  input  logic [WORD_W-1:0]     imem_rdata,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_W-1:0]     redirect_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [2*WORD_W-1:0]   instr,
  output logic [ADDR_W-1:0]     instr_pc,
  output logic                  instr_long
);

  fetch_state_t        state;
  logic [WORD_W-1:0]   word0;
  logic [ADDR_W-1:0]   word0_pc;

  logic                out_free;
  logic                take;
  logic                advance;
  logic                is_long;
  logic                load;
  logic                consume;
  logic [2*WORD_W-1:0] load_instr;
  logic [ADDR_W-1:0]   load_pc;
  logic                load_long;

  assign out_free = !instr_valid || instr_ready;
  assign take     = !stall && ((state == F2) || out_free);
  // F2 completes an instruction, so it also needs room in the output register.
  assign advance  = take && out_free;
  assign is_long  = imem_rdata[LONG_BIT];
  assign consume  = instr_valid && instr_ready;
  assign load     = !redirect && advance && ((state == F2) || !is_long);

  assign pc_dir     = 1'b1;
  assign imem_addr  = pc_val;
  assign pc_en      = redirect || advance;
  assign pc_jmp     = redirect;
  assign pc_jmp_loc = redirect ? redirect_addr : '0;

  always_comb begin
    load_instr = {imem_rdata, WORD_W'(NOP_WORD)};
    load_pc    = pc_val;
    load_long  = 1'b0;
    if (state == F2) begin
      load_instr = {word0, imem_rdata};
      load_pc    = word0_pc;
      load_long  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= F1;
      word0    <= '0;
      word0_pc <= '0;
    end else if (redirect) begin
      // Any half-assembled instruction belongs to the abandoned path.
      state    <= F1;
      word0    <= '0;
      word0_pc <= '0;
    end else if (advance) begin
      case (state)
        F1: begin
          if (is_long) begin
            state    <= F2;
            word0    <= imem_rdata;
            word0_pc <= pc_val;
          end
        end
        F2: state <= F1;
        default: state <= F1;
      endcase
    end
  end

  fetch_out_reg #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .flush       (redirect),
    .consume     (consume),
    .load_instr  (load_instr),
    .load_pc     (load_pc),
    .load_long   (load_long),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_long  (instr_long)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: counter + imem environment, program-order scoreboard, directed and random traffic.
module tb_fetch_unit;

  localparam int AW = 10;
  localparam int WW = 16;

  logic          clk;
  logic          rst;
  logic [AW-1:0] pc_val;
  logic          pc_en;
  logic          pc_dir;
  logic          pc_jmp;
  logic [AW-1:0] pc_jmp_loc;
  logic [AW-1:0] imem_addr;
  logic [WW-1:0] imem_rdata;
  logic          stall;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          instr_valid;
  logic          instr_ready;
  logic [2*WW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_long;

  logic [WW-1:0] imem [0:(1<<AW)-1];

  fetch_unit #(.ADDR_W(AW), .WORD_W(WW), .LONG_BIT(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_val        (pc_val),
    .pc_en         (pc_en),
    .pc_dir        (pc_dir),
    .pc_jmp        (pc_jmp),
    .pc_jmp_loc    (pc_jmp_loc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_long    (instr_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter (ctr, increment direction) and async-read instruction memory.
  assign imem_rdata = imem[imem_addr];
  always @(posedge clk or negedge rst) begin
    if (!rst)       pc_val <= '0;
    else if (pc_en) pc_val <= pc_jmp ? pc_jmp_loc : pc_val + 10'd1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_hs  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the program as a stream of instructions parsed from memory in address order.
  typedef struct packed {
    logic [31:0]   instr;
    logic [AW-1:0] pc;
    logic          lng;
  } exp_t;

  exp_t          q[$];
  logic [AW-1:0] mptr;

  function automatic void refill();
    exp_t          e;
    logic [WW-1:0] w0;
    logic [AW-1:0] nxt;
    while (q.size() < 4) begin
      w0   = imem[mptr];
      nxt  = mptr + 10'd1;
      e.pc = mptr;
      if (w0[15]) begin
        e.instr = {w0, imem[nxt]};
        e.lng   = 1'b1;
        mptr    = nxt + 10'd1;
      end else begin
        e.instr = {w0, 16'h0000};
        e.lng   = 1'b0;
        mptr    = nxt;
      end
      q.push_back(e);
    end
  endfunction

  logic            prev_hold;
  logic [2*WW-1:0] prev_instr;
  logic [AW-1:0]   prev_pc;
  logic            prev_long;

  always @(negedge rst) begin
    q.delete();
    mptr      = '0;
    prev_hold = 1'b0;
  end

  // Monitor: per-cycle control rules, hold stability, and in-order stream compare at each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      q.delete();
      mptr      = '0;
      prev_hold = 1'b0;
    end else begin
      check("pc_dir", pc_dir, 1);
      check("imem_addr", imem_addr, pc_val);
      check("pc_jmp", pc_jmp, redirect);
      check("pc_jmp_loc", pc_jmp_loc, redirect ? redirect_addr : 10'd0);
      if (redirect) check("pc_en_redirect", pc_en, 1);
      else if (stall || (instr_valid && !instr_ready)) check("pc_en_frozen", pc_en, 0);
      if (prev_hold) begin
        check("hold_valid", instr_valid, 1);
        check("hold_instr", instr, prev_instr);
        check("hold_pc", instr_pc, prev_pc);
        check("hold_long", instr_long, prev_long);
      end
      if (instr_valid && instr_ready) begin
        n_hs++;
        if (q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = q.pop_front();
          check("sb_instr", instr, e.instr);
          check("sb_pc", instr_pc, e.pc);
          check("sb_long", instr_long, e.lng);
        end
      end
      if (redirect) begin
        q.delete();
        mptr = redirect_addr;
      end
      refill();
      prev_hold  = instr_valid && !instr_ready && !redirect;
      prev_instr = instr;
      prev_pc    = instr_pc;
      prev_long  = instr_long;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic reset_release();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] w;
    rst           = 1'b0;
    stall         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    instr_ready   = 1'b1;
    for (int i = 0; i < (1 << AW); i++) imem[i] = 16'h0000;
    imem[0]      = 16'h1234;
    imem[1]      = 16'h0ABC;
    imem[2]      = 16'h0001;
    imem[3]      = 16'h8005;
    imem[4]      = 16'h00FF;
    imem['h100]  = 16'h0042;
    imem['h200]  = 16'h8123;
    imem['h201]  = 16'h4567;
    imem['h3FF]  = 16'h8001;

    #12;
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_long", instr_long, 0);
    check("rst_pcval", pc_val, 0);

    // Back-to-back one-word instructions, then one two-word instruction.
    reset_release();
    mid();
    check("t1_c0_pc_en", pc_en, 1);
    check("t1_c0_valid", instr_valid, 0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      mid();
      check("t1_b2b_valid", instr_valid, 1);
      check("t1_b2b_pc", instr_pc, k);
      check("t1_b2b_pc_en", pc_en, 1);
    end
    next_cycle();
    mid();
    check("t1_f2_valid", instr_valid, 0);
    check("t1_f2_pcval", pc_val, 4);
    next_cycle();
    mid();
    check("t1_long_valid", instr_valid, 1);
    check("t1_long_instr", instr, 32'h800500FF);
    check("t1_long_pc", instr_pc, 3);
    check("t1_long_flag", instr_long, 1);
    check("t1_long_pcval", pc_val, 5);

    // Decode backpressure for three cycles with instr@1 held.
    reset_release();
    next_cycle();
    next_cycle();
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mid();
      check("t2_hold_valid", instr_valid, 1);
      check("t2_hold_instr", instr, 32'h0ABC0000);
      check("t2_hold_pc", instr_pc, 1);
      check("t2_hold_pc_en", pc_en, 0);
      check("t2_hold_pcval", pc_val, 2);
      next_cycle();
    end
    instr_ready = 1'b1;
    mid();
    check("t2_release_pc_en", pc_en, 1);
    next_cycle();
    mid();
    check("t2_resume_valid", instr_valid, 1);
    check("t2_resume_pc", instr_pc, 2);

    // Redirect while word0 8005 is pending, then wrap-spanning long instruction.
    reset_release();
    for (int k = 0; k < 4; k++) next_cycle();
    redirect      = 1'b1;
    redirect_addr = 10'h100;
    mid();
    check("t3_jmp", pc_jmp, 1);
    check("t3_jmp_pc_en", pc_en, 1);
    check("t3_jmp_loc", pc_jmp_loc, 10'h100);
    next_cycle();
    redirect      = 1'b0;
    redirect_addr = '0;
    mid();
    check("t3_flush_valid", instr_valid, 0);
    check("t3_target_pcval", pc_val, 10'h100);
    next_cycle();
    imem[0]       = 16'h0007;
    redirect      = 1'b1;
    redirect_addr = 10'h3FF;
    mid();
    check("t3_target_valid", instr_valid, 1);
    check("t3_target_pc", instr_pc, 10'h100);
    check("t3_target_instr", instr, 32'h00420000);
    next_cycle();
    redirect      = 1'b0;
    redirect_addr = '0;
    mid();
    check("t4_pcval_3ff", pc_val, 10'h3FF);
    next_cycle();
    mid();
    check("t4_pcval_wrap", pc_val, 0);
    check("t4_f2_valid", instr_valid, 0);
    next_cycle();
    mid();
    check("t4_wrap_valid", instr_valid, 1);
    check("t4_wrap_instr", instr, 32'h80010007);
    check("t4_wrap_pc", instr_pc, 10'h3FF);
    check("t4_wrap_long", instr_long, 1);
    check("t4_wrap_pcval", pc_val, 1);

    // Stall and redirect together, then reset in the middle of F2.
    next_cycle();
    stall         = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 10'h200;
    mid();
    check("t5_stall_jmp", pc_jmp, 1);
    check("t5_stall_pc_en", pc_en, 1);
    next_cycle();
    stall         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    mid();
    check("t5_target_pcval", pc_val, 10'h200);
    next_cycle();
    mid();
    check("t6_f2_pcval", pc_val, 10'h201);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_valid", instr_valid, 0);
    check("t6_rst_pcval", pc_val, 0);
    next_cycle();
    rst = 1'b1;
    mid();
    check("t6_restart_pc_en", pc_en, 1);
    next_cycle();
    mid();
    check("t6_restart_valid", instr_valid, 1);
    check("t6_restart_pc", instr_pc, 0);
    check("t6_restart_instr", instr, 32'h00070000);

    // Random program with random backpressure, stalls and redirects.
    rst = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      w     = WW'($urandom);
      w[15] = ($urandom_range(0, 99) < 30);
      imem[i] = w;
    end
    reset_release();
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      instr_ready = ($urandom_range(0, 99) < 70);
      stall       = ($urandom_range(0, 99) < 15);
      if (!redirect && ($urandom_range(0, 99) < 5)) begin
        redirect      = 1'b1;
        redirect_addr = ($urandom_range(0, 3) == 0) ? AW'(10'h3FE + 10'($urandom_range(0, 1)))
                                                    : AW'($urandom);
      end else begin
        redirect      = 1'b0;
        redirect_addr = '0;
      end
    end
    next_cycle();
    stall       = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b1;
    for (int c = 0; c < 8; c++) next_cycle();
    mid();
    check("rand_progress", (n_hs > 300), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the program-counter instance of `ctr` (`width`=ADDR_W, `dir` tied to increment).
- Reads the 16-bit instruction memory at the current PC and assembles one- or two-word instructions.
- Presents assembled instructions to decode over a valid/ready handshake.
- Drives the counter's `en`/`jmp`/`jmpLoc` inputs for sequential advance, stall and branch redirect.

Parameters:
- ADDR_W, 10, PC / instruction-memory address width; must equal the counter's `width`.
- WORD_W, 16, instruction-memory word width.
- LONG_BIT, 15, bit of the first word that marks a two-word (immediate-carrying) instruction.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- pc_val  in  ADDR_W  current counter output (`ctrOut`).
- pc_en  out  1  to counter `en`; advance or load this cycle.
- pc_dir  out  1  to counter `dir`; constant 1.
- pc_jmp  out  1  to counter `jmp`.
- pc_jmp_loc  out  ADDR_W  to counter `jmpLoc`.
- imem_addr  out  ADDR_W  instruction-memory read address; equals pc_val.
- imem_rdata  in  WORD_W  asynchronous-read data for imem_addr, valid in the same cycle.
- stall  in  1  hazard-unit freeze.
- redirect  in  1  branch/jump taken; one-cycle pulse.
- redirect_addr  in  ADDR_W  redirect target.
- instr_valid  out  1  instr register holds a valid instruction.
- instr_ready  in  1  decode accepts instr this cycle.
- instr  out  2*WORD_W  {word0, word1}; word1 = 0 for one-word instructions.
- instr_pc  out  ADDR_W  address of word0.
- instr_long  out  1  instruction is two-word.

Behaviour:
- Reset (rst=0, async): state=F1; instr_valid=0; instr=0; instr_pc=0; instr_long=0; word0 holding register=0.
- Counter resets to 0 on the same rst edge; first fetch after release is from address 0.
- pc_dir=1 always; imem_addr=pc_val combinationally.
- Defined signals:
  - out_free = !instr_valid | instr_ready.
  - take = !stall & (state==F2 | out_free).
- State F1:
  - If take: pc_en=1; sample imem_rdata at posedge.
  - If imem_rdata[LONG_BIT]=0: load instr={rdata,0}, instr_pc=pc_val, instr_long=0, instr_valid=1; stay F1.
  - If imem_rdata[LONG_BIT]=1: store word0=rdata and its pc; go F2; instr_valid falls if it was consumed this cycle.
- State F2:
  - Requires out_free, otherwise waits with pc_en=0.
  - On take: pc_en=1; instr={word0,rdata}, instr_long=1, instr_pc=stored pc, instr_valid=1; go F1.
- Handshake:
  - instr_valid & !instr_ready holds instr, instr_pc and instr_long stable and forces pc_en=0.
  - instr_valid & instr_ready with a new word taken gives back-to-back output, one instruction per cycle (one-word case).
  - instr_valid & instr_ready with no new word taken clears instr_valid next cycle.
- Stall: pc_en=0 and no state change; registers hold. Redirect overrides stall.
- Redirect (highest priority):
  - Same cycle: pc_en=1, pc_jmp=1, pc_jmp_loc=redirect_addr.
  - Next posedge: instr_valid=0 and state=F1; any pending word0 is discarded; the word present this cycle is not consumed.
  - Next cycle: pc_val=redirect_addr; first valid instruction from target appears 1 cycle after that.
- Otherwise pc_jmp=0 and pc_jmp_loc=0.
- Wrap-around: PC 2^ADDR_W-1 increments to 0 in the counter. A two-word instruction spanning the wrap is legal; instr_pc=2^ADDR_W-1.
- Latency: one-word instruction is valid one clock after its address appears on pc_val; two-word instruction is valid one clock after its second word's address.
- Reset mid-F2: pending word0 is dropped; fetch restarts at 0.

Decomposition:
- Shared package:
  - fetch state encoding (F1, F2).
  - LONG_BIT constant.
  - NOP word (16'h0000).
  - ADDR_W/WORD_W defaults shared with `ctr`, the memories and decode.
- One sub-module, fetch_out_reg: the instr/instr_pc/instr_long/instr_valid register with hold, load and flush control.
- FSM and counter control stay in fetch_unit.

Test Plan:
- Reset release with imem[0..2]=16'h1234, 16'h0ABC, 16'h0001 and instr_ready=1 -> instrs {1234,0000}@0, {0ABC,0000}@1, {0001,0000}@2 on consecutive cycles; pc_en=1 throughout.
- imem[3]=16'h8005, imem[4]=16'h00FF -> one output instr=32'h800500FF, instr_pc=3, instr_long=1; pc_val reaches 5.
- instr_ready=0 for 3 cycles while instr valid@1 -> instr held at {0ABC,0000}, pc_en=0, pc_val frozen at 2; release resumes with @2 next cycle.
- redirect=1, redirect_addr=10'h100 while in F2 after word0=16'h8005 -> pc_jmp=1 that cycle, instr_valid=0 next cycle, word0 discarded, next instr_pc=10'h100.
- PC at 10'h3FF holding 16'h8001, imem[0]=16'h0007 -> instr=32'h80010007, instr_pc=10'h3FF, pc_val wraps to 0 then 1.
- stall=1 and redirect=1 in the same cycle -> redirect taken (pc_jmp=1, pc_en=1); rst pulse low mid-F2 -> instr_valid=0 immediately, fetch restarts at address 0.
